// File: rtl/dot4_pkg.sv
// Shared Q8.8 types, widths and the controller state for the streaming dot-product MAC.
package dot4_pkg;

    localparam int Q_W    = 16;
    localparam int Q_FRAC = 8;

    typedef logic signed [15:0] q88_t;
    typedef logic signed [31:0] q1616_t;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } dot4_state_e;

endpackage

// File: rtl/q88_scale_sat.sv
// Rescales the wide accumulator back to Q8.8 (floor shift), then saturates or wraps.
// DOT4_SAT_EN defined selects saturation; undefined selects a plain wrap of the low W bits.
module q88_scale_sat #(
    parameter int W    = 16,
    parameter int FRAC = 8,
    parameter int AW   = 34
) (
    input  logic [AW-1:0] acc,
    output logic [W-1:0]  q,
    output logic          ovf
);

    logic signed [AW-1:0] shifted;

    // The shifted value fits in W bits only when every bit above the result's sign bit matches it.
    function automatic logic [W:0] scale(input logic signed [AW-1:0] s);
        logic fits;
        fits = (&s[AW-1:W-1]) || !(|s[AW-1:W-1]);
`ifdef DOT4_SAT_EN
        if (fits)
            return {1'b0, s[W-1:0]};
        return s[AW-1] ? {1'b1, 1'b1, {(W-1){1'b0}}} : {1'b1, 1'b0, {(W-1){1'b1}}};
`else
        return {!fits, s[W-1:0]};
`endif
    endfunction

    assign shifted  = $signed(acc) >>> FRAC;
    assign {ovf, q} = scale(shifted);

endmodule

// File: rtl/dot4_stream_mac.sv
// Streaming N-element Q8.8 dot product: valid/ready in, 2-stage multiply/accumulate, valid/ready out.
// Result saturation is selected by DOT4_SAT_EN inside q88_scale_sat (wrap when undefined).
module dot4_stream_mac
    import dot4_pkg::*;
#(
    parameter int N    = 4,
    parameter int W    = Q_W,
    parameter int FRAC = Q_FRAC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_ovf,
    output logic         err_frame
);

    localparam int CW = $clog2(N);
    localparam int PW = 2 * W;
    localparam int AW = PW + CW;

    dot4_state_e          state;
    logic [CW-1:0]        cnt;
    logic signed [PW-1:0] prod_p1;
    logic                 vld_p1, first_p1, last_p1;
    logic signed [AW-1:0] acc_p2;
    logic signed [AW-1:0] prod_ext;
    logic                 vld_p2;
    logic [W-1:0]         scaled;
    logic                 scaled_ovf;
    logic                 accept, at_end, frame_cut;

    assign in_ready  = (state == ACC) && !rst;
    assign accept    = in_valid && in_ready;
    assign at_end    = (cnt == CW'(N - 1));
    assign frame_cut = accept && in_last && !at_end;
    assign prod_ext  = {{CW{prod_p1[PW-1]}}, prod_p1};

    // Stage 1 data: full-precision Q16.16 product
    always_ff @(posedge clk) begin
        if (accept)
            prod_p1 <= $signed(in_a) * $signed(in_b);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACC;
            cnt       <= '0;
            vld_p1    <= 1'b0;
            first_p1  <= 1'b0;
            last_p1   <= 1'b0;
            acc_p2    <= '0;
            vld_p2    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            err_frame <= 1'b0;
        end else begin
            // Stage 1 control: tag the product, drop it if it ends a short vector
            vld_p1    <= accept && !frame_cut;
            first_p1  <= (cnt == '0);
            last_p1   <= at_end;
            err_frame <= accept && (in_last != at_end);
            if (accept)
                cnt <= (at_end || in_last) ? '0 : cnt + CW'(1);

            // Stage 2: accumulate; the first element of a vector overwrites stale sums
            if (frame_cut)
                acc_p2 <= '0;
            else if (vld_p1)
                acc_p2 <= first_p1 ? prod_ext : acc_p2 + prod_ext;
            vld_p2 <= vld_p1 && last_p1;

            // Result register: load once per vector, then hold until the consumer takes it
            if (vld_p2) begin
                out_valid <= 1'b1;
                out_data  <= scaled;
                out_ovf   <= scaled_ovf;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                ACC:     if (accept && at_end) state <= FLUSH;
                FLUSH:   if (vld_p2) state <= HOLD;
                HOLD:    if (out_valid && out_ready) state <= ACC;
                default: state <= ACC;
            endcase
        end
    end

    q88_scale_sat #(
        .W   (W),
        .FRAC(FRAC),
        .AW  (AW)
    ) u_scale (
        .acc(acc_p2),
        .q  (scaled),
        .ovf(scaled_ovf)
    );

endmodule

// File: doc/dot4_stream_mac.md
# dot4_stream_mac

Streaming, sequential counterpart of the combinational 4×1 Q8.8 dot-product block. It accepts one (a, b) element pair per cycle over a valid/ready input stream and accumulates N pairs through a 2-stage multiply/accumulate pipeline. It then presents the scaled and saturated Q8.8 result on a valid/ready output stream. It sits between the element sequencer that streams matrix rows and the result collector.

## Interface
- `N`, 4 — elements per vector; a power of two, ≥2
- `W`, 16 — element and result width, signed
- `FRAC`, 8 — fractional bits (Q8.8)
- `clk` in 1 — single clock, rising edge
- `rst` in 1 — reset, asynchronous, active-high
- `in_valid` in 1 — element pair valid
- `in_ready` out 1 — block can accept an element
- `in_a` in W — signed Q8.8 element of A
- `in_b` in W — signed Q8.8 element of B
- `in_last` in 1 — producer marks the final element of a vector
- `out_valid` out 1 — result valid
- `out_ready` in 1 — consumer accepts the result
- `out_data` out W — signed Q8.8 dot product
- `out_ovf` out 1 — result was clipped, or wrapped when saturation is compiled out; qualified by `out_valid`
- `err_frame` out 1 — one-cycle pulse on a framing violation

## Operation
- Accept: an element is accepted on a rising edge where `in_valid && in_ready`.
- States:
  - ACC: `in_ready`=1 (forced 0 while `rst`).
  - FLUSH: `in_ready`=0, 2 cycles.
  - HOLD: `out_valid`=1.
- Transitions:
  - ACC→FLUSH on accepting element index N-1.
  - FLUSH→HOLD when the result register loads.
  - HOLD→ACC on `out_valid && out_ready`.
- Element counter: `$clog2(N)` bits. Increments on each accept. Clears on completion or framing error.
- Stage 1 register: product `in_a*in_b`, full 2W-bit signed (Q16.16), tagged first/last.
- Stage 2 register: accumulator, 2W+`$clog2(N)` bits, signed. On the first element, load the product instead of adding it.
- Result: arithmetic shift right by FRAC (truncate toward −∞). Then saturate to W bits: 0x7FFF / 0x8000. Set `out_ovf` if clipped.
- Framing:
  - `in_last` on an accepted element with index ≠ N-1: pulse `err_frame` the next cycle. Discard the partial vector, clear counter and accumulator, stay in ACC. No result.
  - Element N-1 accepted without `in_last`: the vector still completes normally and `err_frame` pulses once.
- `out_data`/`out_ovf` stay stable while `out_valid && !out_ready`.
- Reset values:
  - `in_ready`=0 while `rst`, 1 after release (ACC).
  - `out_valid`=0, `out_data`=0, `out_ovf`=0, `err_frame`=0.
  - Counter, accumulator and pipeline valids = 0.
- Reset mid-vector or in HOLD: all state discarded, no result emitted.

## Timing
- Last element accepted at edge t: product registered at t, accumulated at t+1, result register and `out_valid` set at t+2.
- Input is blocked from the cycle after the last accept until one cycle after the output handshake.
- Minimum period per vector with `out_ready` held high: N+3 cycles.
- `err_frame` is asserted for exactly the cycle after the offending accept edge.
- `in_valid` may drop between elements; gaps do not disturb accumulation.

## Configuration
- `DOT4_SAT_EN` defined: saturating result and `out_ovf` = clipped, as described above.
- `DOT4_SAT_EN` undefined: `out_data` = accumulator bits [FRAC+W-1:FRAC] (wrap), and `out_ovf` = those bits differ from the full shifted value.

## Structure
- Package `dot4_pkg`:
  - `q88_t` (signed [15:0])
  - `q1616_t` (signed [31:0])
  - state enum `dot4_state_e` {ACC, FLUSH, HOLD}
  - constants `Q_W`=16, `Q_FRAC`=8
- Sub-module `q88_scale_sat`: combinational shift plus saturate/wrap. `DOT4_SAT_EN` is tested only here.

## Test plan
- A=[FF80,FF00,0100,FF00], B=[FF00,FF80,FF80,0100], `in_last` on the 4th element, `out_ready`=1 → `out_data`=FF80, `out_ovf`=0, `out_valid` 2 cycles after the 4th accept.
- A=[0080,0180,FE80,FE80], B=[FC80,FC80,0080,FC80] → FD80.
- All A=B=7FFF → SAT_EN: 7FFF with `out_ovf`=1; wrap build: FC00 with `out_ovf`=1.
- `out_ready`=0 for 5 cycles in HOLD → `out_data` stable, `in_ready`=0. On release, the next vector is accepted and its result is correct (accumulator restarted).
- `in_last` on the 2nd element → `err_frame` pulse, no `out_valid`. The next full vector yields the correct result.
- `rst` asserted after 3 elements → outputs at reset values immediately. A following full vector yields the correct result.
